// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, bubble and forwarding control for the 5-stage MIPS core.
// Shadows (wa, we, tnew) of the instructions in E/M/W and compares them with the
// Tuse of the operands of the instruction in ID.
// Optional feature: define HAZARD_MDU_EN to compile in mult/div busy tracking
// (md_* ports, busy counter, MDU stall term).
module hazard_ctrl #(
    parameter int RA_W        = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] rs_D,
    input  logic [RA_W-1:0] rt_D,
    input  logic            use_rs_D,
    input  logic            use_rt_D,
    input  logic [1:0]      tuse_rs_D,
    input  logic [1:0]      tuse_rt_D,
    input  logic [RA_W-1:0] wa_D,
    input  logic            we_D,
    input  logic [1:0]      tnew_D,
`ifdef HAZARD_MDU_EN
    input  logic            md_start_D,
    input  logic            md_div_D,
    input  logic            md_use_D,
`endif
    output logic            stall,
    output logic            flush_E,
    output logic [1:0]      fwd_rs,
    output logic [1:0]      fwd_rt
);

    logic [RA_W-1:0] wa_E, wa_M, wa_W;
    logic            we_E, we_M, we_W;
    logic [1:0]      tnew_E, tnew_M, tnew_W;
    logic            stall_rs, stall_rt, stall_md;

    // A stage matches a source only if it really writes that register; $0 never matches.
    function automatic logic match(input logic we, input logic [RA_W-1:0] wa,
                                   input logic [RA_W-1:0] r);
        return we && (wa == r) && (r != '0);
    endfunction

    // Nearest matching stage decides; if its result is not ready yet, select RF
    // (the stall logic holds ID until the value becomes forwardable).
    function automatic logic [1:0] sel(input logic m_e, input logic m_m, input logic m_w,
                                       input logic [1:0] t_e, input logic [1:0] t_m,
                                       input logic [1:0] t_w);
        if (m_e)      return (t_e == 2'd0) ? 2'd1 : 2'd0;
        else if (m_m) return (t_m == 2'd0) ? 2'd2 : 2'd0;
        else if (m_w) return (t_w == 2'd0) ? 2'd3 : 2'd0;
        else          return 2'd0;
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Shadow pipeline: E takes the ID entry or a bubble, M/W age by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_E <= '0; we_E <= 1'b0; tnew_E <= 2'd0;
            wa_M <= '0; we_M <= 1'b0; tnew_M <= 2'd0;
            wa_W <= '0; we_W <= 1'b0; tnew_W <= 2'd0;
        end else begin
            if (stall) begin
                wa_E <= '0; we_E <= 1'b0; tnew_E <= 2'd0;
            end else begin
                wa_E <= wa_D; we_E <= we_D; tnew_E <= tnew_D;
            end
            wa_M <= wa_E; we_M <= we_E; tnew_M <= dec_sat(tnew_E);
            wa_W <= wa_M; we_W <= we_M; tnew_W <= dec_sat(tnew_M);
        end
    end

    // GPR data hazards: stall when a result in E/M arrives later than ID needs it.
    always_comb begin
        stall_rs = use_rs_D &&
                   ((match(we_E, wa_E, rs_D) && (tnew_E > tuse_rs_D)) ||
                    (match(we_M, wa_M, rs_D) && (tnew_M > tuse_rs_D)));
        stall_rt = use_rt_D &&
                   ((match(we_E, wa_E, rt_D) && (tnew_E > tuse_rt_D)) ||
                    (match(we_M, wa_M, rt_D) && (tnew_M > tuse_rt_D)));
        fwd_rs = sel(match(we_E, wa_E, rs_D), match(we_M, wa_M, rs_D),
                     match(we_W, wa_W, rs_D), tnew_E, tnew_M, tnew_W);
        fwd_rt = sel(match(we_E, wa_E, rt_D), match(we_M, wa_M, rt_D),
                     match(we_W, wa_W, rt_D), tnew_E, tnew_M, tnew_W);
    end

`ifdef HAZARD_MDU_EN
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    logic             start_E, div_E;
    logic [CNT_W-1:0] busy_cnt;

    // Start flag travels with the instruction into E; the counter arms as it leaves E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_E  <= 1'b0;
            div_E    <= 1'b0;
            busy_cnt <= '0;
        end else begin
            start_E <= stall ? 1'b0 : md_start_D;
            div_E   <= stall ? 1'b0 : md_div_D;
            if (start_E)
                busy_cnt <= div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - 1'b1;
        end
    end

    // Any HI/LO or MDU access waits while an op is in E or still busy.
    always_comb stall_md = md_use_D && ((busy_cnt != '0) || start_E);
`else
    assign stall_md = 1'b0;
`endif

    assign stall   = stall_rs | stall_rt | stall_md;
    assign flush_E = stall;

endmodule
